c_frag_cfg_loader: RTL and testbench
====================================

Name: c_frag_cfg_loader

Overview:
- Serial configuration writer for the PP3 logic-cell C_FRAG.
- Accepts a bit-serial truth-table frame over a valid/ready handshake and assembles it in a shadow register.
- Commits the frame atomically to eight registered outputs that drive the C_FRAG data inputs TA1, TA2, TB1, TB2, BA1, BA2, BB1 and BB2.
- Used in simulation and emulation models to program a C_FRAG as a LUT; the fabric drives the select inputs (TBS/TAB/TSL/BAB/BSL).

Parameters:
- INIT, 8'h00: value of the active outputs at reset. Bit0→TA1, bit1→TA2, bit2→TB1, bit3→TB2, bit4→BA1, bit5→BA2, bit6→BB1, bit7→BB2.
- READY_GAP, 1: number of cycles CFG_READY stays low after a commit. Range 0..15.

Ports:
- QCK  input  1  clock; all state updates on the rising edge.
- QRT  input  1  reset; synchronous, active-high.
- CFG_DIN  input  1  serial frame bit, LSB first.
- CFG_VALID  input  1  CFG_DIN is valid.
- CFG_READY  output  1  loader accepts a bit this cycle.
- CFG_ABORT  input  1  discard the partial frame.
- TA1, TA2, TB1, TB2  output  1 each  active config for the top half, bits 0..3.
- BA1, BA2, BB1, BB2  output  1 each  active config for the bottom half, bits 4..7.
- LOAD_DONE  output  1  one-cycle pulse on commit.
- LOAD_ERR  output  1  sticky error flag.

Behaviour:
- Reset (QRT high at an edge):
  - State becomes IDLE; bit counter and shadow register cleared.
  - Active outputs take INIT; LOAD_DONE=0, LOAD_ERR=0.
  - CFG_READY=0 while QRT is high; CFG_READY=1 in the first cycle after QRT drops.
  - QRT mid-frame or during GAP discards everything; there is no partial commit.
- Transfer: a bit transfers at a rising edge where CFG_VALID && CFG_READY.
  - CFG_DIN is ignored when no transfer occurs.
  - VALID may drop between bits without penalty; there is no timeout.
- CFG_READY is a registered decode of state: 1 in IDLE and SHIFT (and CHECK), 0 in COMMIT and GAP.
- States:
  - IDLE:
    - On transfer: shadow[0]=CFG_DIN, cnt=1, go to SHIFT.
  - SHIFT:
    - On transfer: shadow[cnt]=CFG_DIN, cnt++.
    - When the 8th bit transfers (cnt was 7): go to COMMIT, or to CHECK when parity is enabled.
  - CHECK (parity build only):
    - On transfer of the 9th bit: go to COMMIT if parity is good.
    - Otherwise set LOAD_ERR and return to IDLE; active outputs are unchanged.
  - COMMIT (exactly one cycle):
    - At the exiting edge, active outputs take shadow, LOAD_DONE=1 for one cycle, LOAD_ERR clears.
    - Then go to GAP, or to IDLE if READY_GAP=0.
  - GAP:
    - Count READY_GAP cycles, then go to IDLE.
- Latency: last frame bit accepted at edge N → outputs change and LOAD_DONE rises at edge N+1. With READY_GAP=g, CFG_READY is high again after edge N+1+g.
- CFG_ABORT:
  - In IDLE, SHIFT or CHECK: wins over a same-cycle transfer. Clears shadow and cnt, next state IDLE, active outputs unchanged.
  - Sets LOAD_ERR if cnt!=0 at the time of the abort.
  - Ignored in COMMIT and GAP; a commit is atomic.
- LOAD_ERR:
  - Cleared only by reset or a successful commit.
  - A new error while it is already set has no further effect.
- Active outputs change only at a commit edge or on reset; they are glitch-free registers.
- A back-to-back frame may start in the first IDLE cycle after GAP.

Optional Feature:
- Macro: C_FRAG_CFG_PARITY_EN.
- Defined:
  - Frames are 9 bits: 8 data bits plus a trailing odd-parity bit. The XOR of all 9 bits must be 1.
  - The CHECK state exists.
  - A parity mismatch sets LOAD_ERR, drops the frame and returns to IDLE.
- Undefined:
  - Frames are 8 bits; the CHECK state is not built.
  - LOAD_ERR is set only by an abort mid-frame.

Test Plan:
- Reset with INIT=8'h3C, then release → TA1=0, TA2=0, TB1=1, TB2=1, BA1=1, BA2=1, BB1=0, BB2=0; CFG_READY=1 one cycle after QRT drops; LOAD_DONE=0.
- Stream 8'hA5 LSB-first with VALID held high (parity macro off) → one edge after the 8th bit: TA1=1, TA2=0, TB1=1, TB2=0, BA1=0, BA2=1, BB1=0, BB2=1; LOAD_DONE high for exactly 1 cycle; CFG_READY low for 1+READY_GAP cycles.
- Send 5 bits, then assert CFG_ABORT together with CFG_VALID → that bit is not taken; outputs keep the previous value; LOAD_ERR=1. Then a full 8'hFF frame → all outputs 1 and LOAD_ERR=0.
- Parity macro on: send 8'h01 with parity bit 0 (good) → commit. Then send 8'h01 with parity bit 1 (bad) → no LOAD_DONE, outputs stay 8'h01, LOAD_ERR=1.
- Gapped VALID (random 0–3 idle cycles between bits), READY_GAP=0, two back-to-back frames 8'h5A then 8'hC3 → both commit in order; READY high the cycle after the first commit; final outputs correspond to 8'hC3.
- Assert QRT at bit 4 of a frame, then release → outputs return to INIT; the next full frame loads correctly starting from bit 0.

Source files
------------

// File: rtl/c_frag_cfg_loader.sv
// c_frag_cfg_loader
// Serial configuration writer for the PP3 logic-cell C_FRAG data inputs.
// A bit-serial frame (LSB first) is accepted over a valid/ready handshake,
// assembled in a shadow register, and committed atomically to the eight
// registered C_FRAG data outputs (TA1..BB2). The fabric owns the select inputs.
//
// Optional build macro: C_FRAG_CFG_PARITY_EN
//   defined   -> 9-bit frames (8 data + trailing odd-parity bit), CHECK state built
//   undefined -> 8-bit frames, LOAD_ERR only set by a mid-frame abort
module c_frag_cfg_loader #(
    parameter logic [7:0]  INIT      = 8'h00,
    parameter int unsigned READY_GAP = 1
) (
    input  logic QCK,
    input  logic QRT,
    input  logic CFG_DIN,
    input  logic CFG_VALID,
    output logic CFG_READY,
    input  logic CFG_ABORT,
    output logic TA1,
    output logic TA2,
    output logic TB1,
    output logic TB2,
    output logic BA1,
    output logic BA2,
    output logic BB1,
    output logic BB2,
    output logic LOAD_DONE,
    output logic LOAD_ERR
);

    // Index of the last data bit in a frame.
    localparam logic [3:0] LAST_DATA_IDX = 4'd7;

    // Gap counter preload: GAP is left when the counter reads zero, so a gap
    // of g cycles preloads g-1. A zero gap never enters GAP at all.
    localparam logic [3:0] GAP_LOAD = (READY_GAP == 0) ? 4'd0 : 4'(READY_GAP - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
`ifdef C_FRAG_CFG_PARITY_EN
        ST_CHECK  = 3'd2,
`endif
        ST_COMMIT = 3'd3,
        ST_GAP    = 3'd4
    } state_t;

    // State entered once the eighth data bit has been shifted in.
`ifdef C_FRAG_CFG_PARITY_EN
    localparam state_t ST_AFTER_DATA = ST_CHECK;
`else
    localparam state_t ST_AFTER_DATA = ST_COMMIT;
`endif

    state_t      state;
    logic [3:0]  cnt;
    logic [7:0]  shadow;
    logic [3:0]  gap_cnt;
    logic [7:0]  cfg;
    logic        ready;
    logic        done;
    logic        err;
    logic        xfer;

    // CFG_READY is registered; it mirrors "can accept a bit" for the state
    // being entered, so it is low for the cycle right after reset.
    function automatic logic accepts_bits(input state_t s);
        logic r;
        r = 1'b0;
        case (s)
            ST_IDLE:  r = 1'b1;
            ST_SHIFT: r = 1'b1;
`ifdef C_FRAG_CFG_PARITY_EN
            ST_CHECK: r = 1'b1;
`endif
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

`ifdef C_FRAG_CFG_PARITY_EN
    // Odd parity over the full 9-bit frame: XOR of all bits must be 1.
    function automatic logic parity_good(input logic [7:0] data, input logic pbit);
        return ^{pbit, data};
    endfunction
`endif

    assign xfer = CFG_VALID && ready;

    // Loader FSM: shifting, commit, post-commit ready gap and error tracking.
    always_ff @(posedge QCK) begin
        if (QRT) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            shadow  <= 8'h00;
            gap_cnt <= 4'd0;
            cfg     <= INIT;
            ready   <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done  <= 1'b0;
            ready <= accepts_bits(state);
            case (state)
                ST_IDLE, ST_SHIFT: begin
                    if (CFG_ABORT) begin
                        // Abort wins over a same-cycle bit; partial frame is lost.
                        if (cnt != 4'd0) begin
                            err <= 1'b1;
                        end
                        shadow <= 8'h00;
                        cnt    <= 4'd0;
                        state  <= ST_IDLE;
                        ready  <= accepts_bits(ST_IDLE);
                    end else if (xfer) begin
                        shadow[cnt[2:0]] <= CFG_DIN;
                        cnt              <= cnt + 4'd1;
                        if (cnt == LAST_DATA_IDX) begin
                            state <= ST_AFTER_DATA;
                            ready <= accepts_bits(ST_AFTER_DATA);
                        end else begin
                            state <= ST_SHIFT;
                            ready <= accepts_bits(ST_SHIFT);
                        end
                    end
                end
`ifdef C_FRAG_CFG_PARITY_EN
                ST_CHECK: begin
                    if (CFG_ABORT) begin
                        // cnt is still 8 here, so this always flags an error.
                        err    <= 1'b1;
                        shadow <= 8'h00;
                        cnt    <= 4'd0;
                        state  <= ST_IDLE;
                        ready  <= accepts_bits(ST_IDLE);
                    end else if (xfer) begin
                        if (parity_good(shadow, CFG_DIN)) begin
                            state <= ST_COMMIT;
                            ready <= accepts_bits(ST_COMMIT);
                        end else begin
                            err    <= 1'b1;
                            shadow <= 8'h00;
                            cnt    <= 4'd0;
                            state  <= ST_IDLE;
                            ready  <= accepts_bits(ST_IDLE);
                        end
                    end
                end
`endif
                ST_COMMIT: begin
                    // Atomic update of all eight outputs; abort is ignored here.
                    cfg    <= shadow;
                    done   <= 1'b1;
                    err    <= 1'b0;
                    shadow <= 8'h00;
                    cnt    <= 4'd0;
                    if (READY_GAP == 0) begin
                        state <= ST_IDLE;
                        ready <= accepts_bits(ST_IDLE);
                    end else begin
                        gap_cnt <= GAP_LOAD;
                        state   <= ST_GAP;
                        ready   <= accepts_bits(ST_GAP);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == 4'd0) begin
                        state <= ST_IDLE;
                        ready <= accepts_bits(ST_IDLE);
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    cnt    <= 4'd0;
                    shadow <= 8'h00;
                    ready  <= accepts_bits(ST_IDLE);
                end
            endcase
        end
    end

    assign CFG_READY = ready;
    assign LOAD_DONE = done;
    assign LOAD_ERR  = err;

    assign TA1 = cfg[0];
    assign TA2 = cfg[1];
    assign TB1 = cfg[2];
    assign TB2 = cfg[3];
    assign BA1 = cfg[4];
    assign BA2 = cfg[5];
    assign BB1 = cfg[6];
    assign BB2 = cfg[7];

endmodule

// File: tb/tb_c_frag_cfg_loader.sv
// Bench for c_frag_cfg_loader. Two instances share clock and reset:
// u0 uses READY_GAP=1, u1 uses READY_GAP=0; both use INIT=8'h3C.
// A frame-level model (bit list + busy countdown) is compared every cycle,
// and directed checks pin hand-computed values.
module tb_c_frag_cfg_loader;

    localparam logic [7:0] INIT_V = 8'h3C;
`ifdef C_FRAG_CFG_PARITY_EN
    localparam int FRAME = 9;
`else
    localparam int FRAME = 8;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din   [2];
    logic valid [2];
    logic abort [2];

    wire       rdy0, rdy1, dn0, dn1, er0, er1;
    wire [7:0] q0, q1;

    int checks = 0;
    int errors = 0;
    int ndone [2];
    bit started = 1'b0;

    // model state
    logic [7:0] m_cfg   [2];
    logic       m_ready [2];
    logic       m_done  [2];
    logic       m_err   [2];
    int         m_busy  [2];
    bit         m_pend  [2];
    logic [7:0] m_pval  [2];
    logic [8:0] m_bits  [2];
    int         m_n     [2];

    always #5 clk = ~clk;

    c_frag_cfg_loader #(.INIT(INIT_V), .READY_GAP(1)) u0 (
        .QCK(clk), .QRT(rst), .CFG_DIN(din[0]), .CFG_VALID(valid[0]),
        .CFG_READY(rdy0), .CFG_ABORT(abort[0]),
        .TA1(q0[0]), .TA2(q0[1]), .TB1(q0[2]), .TB2(q0[3]),
        .BA1(q0[4]), .BA2(q0[5]), .BB1(q0[6]), .BB2(q0[7]),
        .LOAD_DONE(dn0), .LOAD_ERR(er0)
    );

    c_frag_cfg_loader #(.INIT(INIT_V), .READY_GAP(0)) u1 (
        .QCK(clk), .QRT(rst), .CFG_DIN(din[1]), .CFG_VALID(valid[1]),
        .CFG_READY(rdy1), .CFG_ABORT(abort[1]),
        .TA1(q1[0]), .TA2(q1[1]), .TB1(q1[2]), .TB2(q1[3]),
        .BA1(q1[4]), .BA2(q1[5]), .BB1(q1[6]), .BB2(q1[7]),
        .LOAD_DONE(dn1), .LOAD_ERR(er1)
    );

    function automatic logic       g_rdy(input int k); return (k == 0) ? rdy0 : rdy1; endfunction
    function automatic logic       g_dn (input int k); return (k == 0) ? dn0  : dn1;  endfunction
    function automatic logic       g_er (input int k); return (k == 0) ? er0  : er1;  endfunction
    function automatic logic [7:0] g_q  (input int k); return (k == 0) ? q0   : q1;   endfunction

    task automatic chk(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t: got %h expected %h", name, k, $time, act, exp);
        end
    endtask

    // Frame-level model advanced once per clock edge.
    task automatic model_step(input int k, input int gap);
        if (rst) begin
            m_cfg[k] = INIT_V; m_ready[k] = 1'b0; m_done[k] = 1'b0; m_err[k] = 1'b0;
            m_busy[k] = 0; m_pend[k] = 1'b0; m_bits[k] = '0; m_n[k] = 0;
            started = 1'b1;
            return;
        end
        m_done[k] = 1'b0;
        if (m_pend[k]) begin
            m_cfg[k]   = m_pval[k];
            m_done[k]  = 1'b1;
            m_err[k]   = 1'b0;
            m_busy[k]  = gap;
            m_ready[k] = (gap == 0);
            m_pend[k]  = 1'b0;
        end else if (m_busy[k] > 0) begin
            m_busy[k]  = m_busy[k] - 1;
            m_ready[k] = (m_busy[k] == 0);
        end else if (abort[k]) begin
            if (m_n[k] != 0) m_err[k] = 1'b1;
            m_n[k] = 0; m_bits[k] = '0; m_ready[k] = 1'b1;
        end else if (valid[k] && m_ready[k]) begin
            m_bits[k][m_n[k]] = din[k];
            m_n[k] = m_n[k] + 1;
            if (m_n[k] == FRAME) begin
                if (FRAME == 8 || (^m_bits[k]) == 1'b1) begin
                    m_pend[k]  = 1'b1;
                    m_pval[k]  = m_bits[k][7:0];
                    m_ready[k] = 1'b0;
                end else begin
                    m_err[k] = 1'b1;
                end
                m_n[k] = 0; m_bits[k] = '0;
            end
        end else begin
            m_ready[k] = 1'b1;
        end
    endtask

    // model update on the active edge
    always @(posedge clk) begin
        model_step(0, 1);
        model_step(1, 0);
    end

    // compare process on the opposite edge
    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                chk("ready", k, {7'b0, g_rdy(k)}, {7'b0, m_ready[k]});
                chk("done",  k, {7'b0, g_dn(k)},  {7'b0, m_done[k]});
                chk("err",   k, {7'b0, g_er(k)},  {7'b0, m_err[k]});
                chk("cfg",   k, g_q(k), m_cfg[k]);
                if (g_dn(k) === 1'b1) ndone[k]++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin valid[k] = 1'b0; abort[k] = 1'b0; din[k] = 1'b0; end
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Present one bit and hold it until it is accepted (bounded wait).
    task automatic send_bit(input int k, input logic b);
        bit ok;
        ok = 1'b0;
        din[k] = b;
        valid[k] = 1'b1;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (g_rdy(k) === 1'b1) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        valid[k] = 1'b0;
        din[k] = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout inst%0d: got no ready expected ready within 50 cycles", k);
        end
    endtask

    task automatic send_bits(input int k, input logic [8:0] w, input int n, input int maxgap);
        for (int i = 0; i < n; i++) begin
            send_bit(k, w[i]);
            if (maxgap > 0) repeat ($urandom_range(maxgap)) tick();
        end
    endtask

    // Full frame; the parity build appends the odd-parity bit.
    task automatic send_frame(input int k, input logic [7:0] d, input int maxgap);
        logic [8:0] w;
        w = {~^d, d};
        send_bits(k, w, FRAME, maxgap);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            din[k] = 1'b0; valid[k] = 1'b0; abort[k] = 1'b0; ndone[k] = 0;
        end

        // Reset and release
        do_reset();
        @(negedge clk);
        chk("lit_init_cfg", 0, q0, 8'h3C);
        chk("lit_init_bits", 0, {BB2_of(q0), BB1_of(q0), BA2_of(q0), BA1_of(q0),
                                 TB2_of(q0), TB1_of(q0), TA2_of(q0), TA1_of(q0)}, 8'h3C);
        chk("lit_init_done", 0, {7'b0, dn0}, 8'h00);
        chk("lit_ready_low_before_edge", 0, {7'b0, rdy0}, 8'h00);
        @(negedge clk);
        chk("lit_ready_after_release", 0, {7'b0, rdy0}, 8'h01);

        // A5 with VALID held high, READY_GAP=1
        @(posedge clk); #1;
        send_frame(0, 8'hA5, 0);
        @(negedge clk);
        chk("lit_a5_not_yet", 0, q0, 8'h3C);
        chk("lit_a5_ready_low1", 0, {7'b0, rdy0}, 8'h00);
        @(negedge clk);
        chk("lit_a5_cfg", 0, q0, 8'hA5);
        chk("lit_a5_done", 0, {7'b0, dn0}, 8'h01);
        chk("lit_a5_ready_low2", 0, {7'b0, rdy0}, 8'h00);
        @(negedge clk);
        chk("lit_a5_done_pulse", 0, {7'b0, dn0}, 8'h00);
        chk("lit_a5_ready_back", 0, {7'b0, rdy0}, 8'h01);
        @(posedge clk); #1;

        // Five bits, then abort together with a valid bit
        send_bits(0, 9'h01F, 5, 0);
        din[0] = 1'b1; valid[0] = 1'b1; abort[0] = 1'b1;
        tick();
        valid[0] = 1'b0; abort[0] = 1'b0; din[0] = 1'b0;
        @(negedge clk);
        chk("lit_abort_cfg", 0, q0, 8'hA5);
        chk("lit_abort_err", 0, {7'b0, er0}, 8'h01);
        @(posedge clk); #1;
        send_frame(0, 8'hFF, 0);
        repeat (3) @(negedge clk);
        chk("lit_ff_cfg", 0, q0, 8'hFF);
        chk("lit_ff_err_clear", 0, {7'b0, er0}, 8'h00);
        @(posedge clk); #1;

`ifdef C_FRAG_CFG_PARITY_EN
        // 8'h01 with good parity bit 0, then with bad parity bit 1
        send_bits(0, 9'h001, 9, 0);
        repeat (3) @(negedge clk);
        chk("lit_par_good_cfg", 0, q0, 8'h01);
        begin
            int before;
            before = ndone[0];
            @(posedge clk); #1;
            send_bits(0, 9'h101, 9, 0);
            repeat (3) @(negedge clk);
            chk("lit_par_bad_cfg", 0, q0, 8'h01);
            chk("lit_par_bad_err", 0, {7'b0, er0}, 8'h01);
            chk("lit_par_bad_nodone", 0, 8'(ndone[0] - before), 8'h00);
        end
        @(posedge clk); #1;
`endif

        // Gapped VALID, READY_GAP=0, back-to-back 5A then C3
        send_frame(1, 8'h5A, 3);
        send_frame(1, 8'hC3, 3);
        repeat (3) @(negedge clk);
        chk("lit_b2b_cfg", 1, q1, 8'hC3);
        chk("lit_b2b_commits", 1, 8'(ndone[1]), 8'h02);
        @(posedge clk); #1;

        // Reset in the middle of a frame
        send_bits(0, 9'h00F, 4, 0);
        do_reset();
        @(negedge clk);
        chk("lit_midreset_cfg", 0, q0, 8'h3C);
        chk("lit_midreset_cfg1", 1, q1, 8'h3C);
        @(posedge clk); #1;
        send_frame(0, 8'h96, 1);
        repeat (3) @(negedge clk);
        chk("lit_after_reset_cfg", 0, q0, 8'h96);
        chk("lit_after_reset_err", 0, {7'b0, er0}, 8'h00);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Named views of the output bus, used to pin the bit-to-port mapping.
    function automatic logic TA1_of(input logic [7:0] q); return q[0]; endfunction
    function automatic logic TA2_of(input logic [7:0] q); return q[1]; endfunction
    function automatic logic TB1_of(input logic [7:0] q); return q[2]; endfunction
    function automatic logic TB2_of(input logic [7:0] q); return q[3]; endfunction
    function automatic logic BA1_of(input logic [7:0] q); return q[4]; endfunction
    function automatic logic BA2_of(input logic [7:0] q); return q[5]; endfunction
    function automatic logic BB1_of(input logic [7:0] q); return q[6]; endfunction
    function automatic logic BB2_of(input logic [7:0] q); return q[7]; endfunction

endmodule
